video_sync_shifter: RTL and testbench

Sits directly downstream of the OSD overlay stage. It consumes the overlaid RGB, sync and blank signals and the signed `h_offset_out` / `v_offset_out` values that stage produces, and moves the picture on the display. It does this by re-timing hsync (in pixels) and vsync (in lines) relative to a fixed-delay copy of the video and blank signals. Offsets are applied only at frame boundaries, so a frame never tears.

---
 rtl/video_sync_shifter.sv | 222 ++++++++++++++++++++++
 tb/tb_video_sync_shifter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/video_sync_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : video_sync_shifter
//  Purpose  : Moves the picture on the display. The video and blank signals
//             pass through a fixed delay of H_BASE+1 pixel ticks. hsync is
//             re-timed in pixels and vsync in lines relative to that delayed
//             video. Offsets are latched only on the vsync rising edge, so a
//             frame never tears.
//  Ports    : clk, reset          - clock, synchronous active-high reset
//             pixel_ce            - pixel strobe; all shifting advances on it
//             enable              - 0 latches zero offsets at the frame edge
//             h_offset, v_offset  - signed requested offsets (+ = right/down)
//             R/G/B_in, h/vsync_in, h/vblank_in - overlaid video input
//             R/G/B_out, h/vblank_out         - fixed-delay video and blanks
//             hsync_out, vsync_out            - re-timed syncs
//             h/v_ofs_applied                 - offsets in effect this frame
//  Revision : 1.0 - initial release
// ============================================================================
module video_sync_shifter #(
  parameter int MAX_OFS = 15,
  parameter int H_STEP  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pixel_ce,
  input  logic              enable,
  input  logic signed [4:0] h_offset,
  input  logic signed [4:0] v_offset,
  input  logic        [7:0] R_in,
  input  logic        [7:0] G_in,
  input  logic        [7:0] B_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              hblank_in,
  input  logic              vblank_in,
  output logic        [7:0] R_out,
  output logic        [7:0] G_out,
  output logic        [7:0] B_out,
  output logic              hblank_out,
  output logic              vblank_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic signed [4:0] h_ofs_applied,
  output logic signed [4:0] v_ofs_applied
);

  localparam int H_BASE       = MAX_OFS * H_STEP;
  localparam int c_SYNC_DEPTH = 2 * H_BASE + 1;
  localparam int c_TAP_W      = (c_SYNC_DEPTH > 1) ? $clog2(c_SYNC_DEPTH) : 1;
  localparam int c_CNT_W      = (MAX_OFS > 0) ? $clog2(2 * MAX_OFS + 1) : 1;

  // Saturate a requested offset to [-MAX_OFS, +MAX_OFS].
  function automatic logic signed [4:0] f_clamp(input logic signed [4:0] v);
    if (int'(v) > MAX_OFS)
      return 5'(MAX_OFS);
    else if (int'(v) < -MAX_OFS)
      return 5'(-MAX_OFS);
    else
      return v;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic                     r_vs_prev;
  logic                     r_hs_prev;
  logic signed [4:0]        r_hofs;
  logic signed [4:0]        r_vofs;
  logic [c_TAP_W-1:0]       r_tap;          // sync tap index = Ds-1
  logic [c_CNT_W-1:0]       r_rise_cnt;
  logic                     r_rise_pend;
  logic [c_CNT_W-1:0]       r_fall_cnt;
  logic                     r_fall_pend;
  logic                     r_vs_gen;
  logic [25:0]              r_vid  [H_BASE+1];
  logic [1:0]               r_sync [c_SYNC_DEPTH];

  // --------------------------------------------------------------------------
  // Edge detection and newly requested offsets
  // --------------------------------------------------------------------------
  logic                     w_vs_rise;
  logic                     w_vs_fall;
  logic                     w_line;
  logic signed [4:0]        w_hofs_new;
  logic signed [4:0]        w_vofs_new;
  logic [c_CNT_W-1:0]       w_n_rise;
  logic [c_CNT_W-1:0]       w_n_fall;
  logic [c_TAP_W-1:0]       w_tap_new;

  assign w_vs_rise  = pixel_ce &  vsync_in & ~r_vs_prev;
  assign w_vs_fall  = pixel_ce & ~vsync_in &  r_vs_prev;
  assign w_line     = pixel_ce &  hsync_in & ~r_hs_prev;

  assign w_hofs_new = enable ? f_clamp(h_offset) : 5'sd0;
  assign w_vofs_new = enable ? f_clamp(v_offset) : 5'sd0;

  // The rise delay must use the offset being latched on this very tick; the
  // fall delay uses the one already latched for the current frame.
  assign w_n_rise   = c_CNT_W'(MAX_OFS - int'(w_vofs_new));
  assign w_n_fall   = c_CNT_W'(MAX_OFS - int'(r_vofs));
  assign w_tap_new  = c_TAP_W'(H_BASE - int'(w_hofs_new) * H_STEP);

  // --------------------------------------------------------------------------
  // Vertical generator next state
  // --------------------------------------------------------------------------
  logic [c_CNT_W-1:0]       w_rise_cnt_nx;
  logic                     w_rise_pend_nx;
  logic [c_CNT_W-1:0]       w_fall_cnt_nx;
  logic                     w_fall_pend_nx;
  logic                     w_set;
  logic                     w_clr;
  logic                     w_vs_gen_nx;

  always_comb begin
    w_rise_cnt_nx  = r_rise_cnt;
    w_rise_pend_nx = r_rise_pend;
    w_fall_cnt_nx  = r_fall_cnt;
    w_fall_pend_nx = r_fall_pend;
    w_set          = 1'b0;
    w_clr          = 1'b0;

    // A fresh edge reloads its counter even if a line event lands on the
    // same tick: the latest edge wins.
    if (w_vs_rise) begin
      if (w_n_rise == '0) begin
        w_set          = 1'b1;
        w_rise_pend_nx = 1'b0;
      end else begin
        w_rise_cnt_nx  = w_n_rise;
        w_rise_pend_nx = 1'b1;
      end
    end else if (w_line && r_rise_pend) begin
      if (r_rise_cnt == c_CNT_W'(1)) begin
        w_set          = 1'b1;
        w_rise_pend_nx = 1'b0;
      end else begin
        w_rise_cnt_nx  = r_rise_cnt - c_CNT_W'(1);
      end
    end

    if (w_vs_fall) begin
      if (w_n_fall == '0) begin
        w_clr          = 1'b1;
        w_fall_pend_nx = 1'b0;
      end else begin
        w_fall_cnt_nx  = w_n_fall;
        w_fall_pend_nx = 1'b1;
      end
    end else if (w_line && r_fall_pend) begin
      if (r_fall_cnt == c_CNT_W'(1)) begin
        w_clr          = 1'b1;
        w_fall_pend_nx = 1'b0;
      end else begin
        w_fall_cnt_nx  = r_fall_cnt - c_CNT_W'(1);
      end
    end

    // Clear dominates a coincident set.
    if (w_clr)
      w_vs_gen_nx = 1'b0;
    else if (w_set)
      w_vs_gen_nx = 1'b1;
    else
      w_vs_gen_nx = r_vs_gen;
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vs_prev   <= 1'b0;
      r_hs_prev   <= 1'b0;
      r_hofs      <= 5'sd0;
      r_vofs      <= 5'sd0;
      r_tap       <= c_TAP_W'(H_BASE);
      r_rise_cnt  <= '0;
      r_rise_pend <= 1'b0;
      r_fall_cnt  <= '0;
      r_fall_pend <= 1'b0;
      r_vs_gen    <= 1'b0;
      for (int i = 0; i <= H_BASE; i++)
        r_vid[i] <= '0;
      for (int i = 0; i < c_SYNC_DEPTH; i++)
        r_sync[i] <= '0;
    end else if (pixel_ce) begin
      r_vs_prev   <= vsync_in;
      r_hs_prev   <= hsync_in;
      r_rise_cnt  <= w_rise_cnt_nx;
      r_rise_pend <= w_rise_pend_nx;
      r_fall_cnt  <= w_fall_cnt_nx;
      r_fall_pend <= w_fall_pend_nx;
      r_vs_gen    <= w_vs_gen_nx;

      if (w_vs_rise) begin
        r_hofs <= w_hofs_new;
        r_vofs <= w_vofs_new;
        r_tap  <= w_tap_new;
      end

      r_vid[0] <= {R_in, G_in, B_in, hblank_in, vblank_in};
      for (int i = 1; i <= H_BASE; i++)
        r_vid[i] <= r_vid[i-1];

      // The generator's next value enters alongside the hsync that caused it,
      // so the delayed vsync edge lines up exactly with the delayed hsync.
      r_sync[0] <= {hsync_in, w_vs_gen_nx};
      for (int i = 1; i < c_SYNC_DEPTH; i++)
        r_sync[i] <= r_sync[i-1];
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (taps of registers; they only change on pixel_ce ticks)
  // --------------------------------------------------------------------------
  assign {R_out, G_out, B_out, hblank_out, vblank_out} = r_vid[H_BASE];
  assign {hsync_out, vsync_out} = r_sync[r_tap];
  assign h_ofs_applied = r_hofs;
  assign v_ofs_applied = r_vofs;

endmodule
`default_nettype wire

// File: tb/tb_video_sync_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_video_sync_shifter
//  Purpose  : Directed self-checking bench for video_sync_shifter with the
//             default parameters (MAX_OFS=15, H_STEP=1, H_BASE=15).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_video_sync_shifter;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              pixel_ce = 1'b1;
  logic              enable = 1'b1;
  logic signed [4:0] h_offset = '0;
  logic signed [4:0] v_offset = '0;
  logic        [7:0] R_in = '0, G_in = '0, B_in = '0;
  logic              hsync_in = 1'b0, vsync_in = 1'b0;
  logic              hblank_in = 1'b0, vblank_in = 1'b0;
  logic        [7:0] R_out, G_out, B_out;
  logic              hblank_out, vblank_out, hsync_out, vsync_out;
  logic        [4:0] h_app, v_app;

  int n_cmp  = 0;
  int n_fail = 0;

  video_sync_shifter #(.MAX_OFS(15), .H_STEP(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .pixel_ce      (pixel_ce),
    .enable        (enable),
    .h_offset      (h_offset),
    .v_offset      (v_offset),
    .R_in          (R_in),
    .G_in          (G_in),
    .B_in          (B_in),
    .hsync_in      (hsync_in),
    .vsync_in      (vsync_in),
    .hblank_in     (hblank_in),
    .vblank_in     (vblank_in),
    .R_out         (R_out),
    .G_out         (G_out),
    .B_out         (B_out),
    .hblank_out    (hblank_out),
    .vblank_out    (vblank_out),
    .hsync_out     (hsync_out),
    .vsync_out     (vsync_out),
    .h_ofs_applied (h_app),
    .v_ofs_applied (v_app)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; vsync_in = 1'b0; hsync_in = 1'b0;
    R_in = '0; G_in = '0; B_in = '0; hblank_in = 1'b0; vblank_in = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  // One line: a single-tick hsync pulse followed by three idle ticks.
  task automatic line();
    hsync_in = 1'b1; tick();
    hsync_in = 1'b0; tick(3);
  endtask

  logic seen;

  initial begin
    // Reset state
    tick(3);
    check("rst_video", {R_out, G_out, B_out, hblank_out, vblank_out}, 32'h0);
    check("rst_sync",  {hsync_out, vsync_out}, 32'h0);
    check("rst_ofs",   {h_app, v_app}, 32'h0);
    reset = 1'b0;

    // Video latency 16 ticks, hold while pixel_ce is low
    R_in = 8'hA5; G_in = 8'h3C; B_in = 8'h81; hblank_in = 1'b1; tick();
    R_in = '0; G_in = '0; B_in = '0; hblank_in = 1'b0; tick(14);
    check("vid_lat15", {R_out, G_out, B_out, hblank_out, vblank_out}, 32'h0);
    tick();
    check("vid_lat16", {R_out, G_out, B_out, hblank_out, vblank_out}, {6'h0, 8'hA5, 8'h3C, 8'h81, 2'b10});
    pixel_ce = 1'b0; tick(3);
    check("vid_hold",  {R_out, G_out, B_out, hblank_out, vblank_out}, {6'h0, 8'hA5, 8'h3C, 8'h81, 2'b10});
    pixel_ce = 1'b1; tick();
    check("vid_next",  {R_out, G_out, B_out, hblank_out, vblank_out}, 32'h0);

    // hsync latency 16 with zero offset
    hsync_in = 1'b1; tick(); hsync_in = 1'b0; tick(14);
    check("hs0_lat15", hsync_out, 32'h0);
    tick();
    check("hs0_lat16", hsync_out, 32'h1);
    tick();
    check("hs0_width", hsync_out, 32'h0);

    // vsync rises/falls 15 lines after vsync_in, aligned with delayed hsync
    vsync_in = 1'b1; tick();
    repeat (14) line();
    hsync_in = 1'b1; tick(); hsync_in = 1'b0; tick(14);
    check("vs0_pre",  vsync_out, 32'h0);
    tick();
    check("vs0_rise", {hsync_out, vsync_out}, 32'h3);
    vsync_in = 1'b0; tick();
    repeat (14) line();
    hsync_in = 1'b1; tick(); hsync_in = 1'b0; tick(14);
    check("vs0_hold", vsync_out, 32'h1);
    tick();
    check("vs0_fall", {hsync_out, vsync_out}, 32'h2);

    // h_offset=+15: Ds=1, video still 16
    do_reset();
    h_offset = 5'sd15; vsync_in = 1'b1; tick();
    check("h15_app", h_app, 32'h0F);
    tick(2);
    hsync_in = 1'b1; tick();
    check("h15_ds1", hsync_out, 32'h1);
    hsync_in = 1'b0; tick();
    check("h15_ds1_end", hsync_out, 32'h0);
    R_in = 8'h5A; tick(); R_in = '0; tick(14);
    check("h15_vid15", R_out, 32'h0);
    tick();
    check("h15_vid16", R_out, 32'h5A);

    // h_offset=-15: Ds=31
    vsync_in = 1'b0; tick(2);
    h_offset = 5'b10001; vsync_in = 1'b1; tick();
    check("hm15_app", h_app, 32'h11);
    tick(32);
    hsync_in = 1'b1; tick(); hsync_in = 1'b0; tick(29);
    check("hm15_lat30", hsync_out, 32'h0);
    tick();
    check("hm15_lat31", hsync_out, 32'h1);

    // v_offset=+15: vsync_out follows vsync_in with no line delay
    do_reset();
    h_offset = '0; v_offset = 5'sd15; vsync_in = 1'b1; tick();
    check("v15_app", v_app, 32'h0F);
    tick(14);
    check("v15_pre", vsync_out, 32'h0);
    tick();
    check("v15_rise", vsync_out, 32'h1);
    vsync_in = 1'b0; tick(); tick(14);
    check("v15_hold", vsync_out, 32'h1);
    tick();
    check("v15_fall", vsync_out, 32'h0);

    // v_offset=-15: 30 lines of delay
    do_reset();
    v_offset = 5'b10001; vsync_in = 1'b1; tick();
    repeat (29) line();
    hsync_in = 1'b1; tick(); hsync_in = 1'b0; tick(14);
    check("vm15_pre", vsync_out, 32'h0);
    tick();
    check("vm15_rise", {hsync_out, vsync_out}, 32'h3);

    // Mid-frame h_offset change takes effect at the next vsync rise only
    do_reset();
    h_offset = '0; v_offset = '0; vsync_in = 1'b1; tick();
    h_offset = 5'sd5; tick(2);
    check("mid_app_old", h_app, 32'h0);
    hsync_in = 1'b1; tick(); hsync_in = 1'b0; tick(14);
    check("mid_old15", hsync_out, 32'h0);
    tick();
    check("mid_old16", hsync_out, 32'h1);
    vsync_in = 1'b0; tick(2);
    vsync_in = 1'b1; tick();
    check("mid_app_new", h_app, 32'h05);
    tick(20);
    hsync_in = 1'b1; tick(); hsync_in = 1'b0; tick(9);
    check("mid_new10", hsync_out, 32'h0);
    tick();
    check("mid_new11", hsync_out, 32'h1);

    // Clamping and enable=0
    do_reset();
    h_offset = 5'b10000; v_offset = 5'b10000; vsync_in = 1'b1; tick();
    check("clamp_m16", {h_app, v_app}, {22'h0, 5'h11, 5'h11});
    vsync_in = 1'b0; tick();
    enable = 1'b0; h_offset = 5'sd4; v_offset = 5'sd7; vsync_in = 1'b1; tick();
    check("dis_v", v_app, 32'h0);
    check("dis_h", h_app, 32'h0);
    enable = 1'b1;

    // Reset during a pending vsync delay, with pixel_ce low
    do_reset();
    h_offset = 5'sd3; v_offset = '0; vsync_in = 1'b1; R_in = 8'hFF; tick();
    repeat (5) line();
    check("pre_rst_app", h_app, 32'h03);
    check("pre_rst_R",   R_out, 32'hFF);
    reset = 1'b1; pixel_ce = 1'b0; vsync_in = 1'b0; tick();
    check("mrst_video", {R_out, G_out, B_out, hblank_out, vblank_out}, 32'h0);
    check("mrst_sync",  {hsync_out, vsync_out}, 32'h0);
    check("mrst_ofs",   {h_app, v_app}, 32'h0);
    reset = 1'b0; pixel_ce = 1'b1; R_in = '0;
    seen = 1'b0;
    repeat (20) begin
      hsync_in = 1'b1; tick(); seen = seen | vsync_out;
      hsync_in = 1'b0;
      repeat (3) begin
        tick(); seen = seen | vsync_out;
      end
    end
    check("no_stale_vs", seen, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
